data_island_scheduler: RTL and testbench
========================================

DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, 800, total pixels per line including blanking.
REQ-002 SHALL have parameter SCREEN_WIDTH, 640, active pixels per line.
REQ-003 SHALL have parameter BIT_WIDTH, 10, width of cx.
REQ-004 SHALL have parameter MAX_PACKETS, 18, upper bound on packets per island.
REQ-005 SHALL have port clk_pixel  input  1  pixel clock; the block uses one clock only.
REQ-006 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port cx  input  BIT_WIDTH  current pixel column, 0..FRAME_WIDTH-1, incrementing by one per cycle.
REQ-008 SHALL have port data_island_enable  input  1  0 = DVI mode, no islands are started.
REQ-009 SHALL have port packet_pending  input  1  the packet picker has a non-null packet queued.
REQ-010 SHALL have port mode  output  3  period type: CTRL, DI_PREAMBLE, DI_GUARD_LEAD, DI_DATA, DI_GUARD_TRAIL.
REQ-011 SHALL have port packet_enable  output  1  single-cycle request for the picker to latch the next packet.
REQ-012 SHALL have port packet_pixel_counter  output  5  position within the current 32-pixel packet.
REQ-013 SHALL have port overrun  output  1  sticky error flag, set when an island collides with active video.

Function
REQ-014 SHALL compute N_FIT = min(MAX_PACKETS, floor((FRAME_WIDTH - SCREEN_WIDTH - 30)/32)) at elaboration; N_FIT == 0 means no island is ever started.
REQ-015 SHALL define ISLAND_START = SCREEN_WIDTH + 4.
REQ-016 SHALL leave CTRL for DI_PREAMBLE on the cycle after cx == ISLAND_START only if data_island_enable && packet_pending && N_FIT > 0.
REQ-017 SHALL hold DI_PREAMBLE for exactly 8 cycles, then DI_GUARD_LEAD for exactly 2 cycles.
REQ-018 SHALL pulse packet_enable on the last DI_GUARD_LEAD cycle.
REQ-019 SHALL then hold DI_DATA for whole packets, with packet_pixel_counter counting 0..31 and wrapping to 0.
REQ-020 SHALL, at packet_pixel_counter == 31, continue to a further packet only if packet_pending == 1 and packets_sent < N_FIT; packet_enable pulses on that same cycle.
REQ-021 SHALL otherwise go to DI_GUARD_TRAIL for exactly 2 cycles, then CTRL.
REQ-022 SHALL send at least one packet per island, even if packet_pending falls during the preamble.
REQ-023 SHALL start at most one island per line.
REQ-024 SHALL reset packets_sent to 0 at every island start.
REQ-025 SHALL hold packet_pixel_counter at 0 outside DI_DATA.
REQ-026 SHALL, if cx < SCREEN_WIDTH while mode != CTRL, return to CTRL on the next cycle without a trailing guard, set overrun, and emit no packet_enable.
REQ-027 SHALL latch data_island_enable only at island start; deassertion mid-island completes the island normally.
REQ-028 SHALL keep every output registered; mode changes exactly on the cycle boundaries defined above.

Reset
REQ-029 SHALL, on reset, set mode = CTRL, packet_enable = 0, packet_pixel_counter = 0, packets_sent = 0 and overrun = 0 in the next cycle.
REQ-030 SHALL, on reset asserted mid-island, abort the island immediately with no trailing guard and no packet_enable.
REQ-031 SHALL, after reset, wait for the next cx == ISLAND_START before starting any island.

Structure
REQ-032 SHALL take the mode enum and constants PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32 and MAX_PACKETS_SPEC=18 from the shared hdmi_pkg package.
REQ-033 SHALL be a single module with inline counters and no sub-module.
REQ-034 SHALL drive packet_picker via packet_enable and packet_pixel_counter.

Verification
REQ-035 SHALL cover: defaults with packet_pending held high, so N_FIT = 4 -> preamble at cx 645..652, guard at 653..654, 4 packets at 655..782, trailing guard at 783..784, 4 packet_enable pulses.
REQ-036 SHALL cover: packet_pending high only at cx 644, then low -> exactly 1 packet, trailing guard at 687..688.
REQ-037 SHALL cover: data_island_enable = 0 -> mode stays CTRL and packet_enable never pulses over 3 lines.
REQ-038 SHALL cover: reset asserted at cx 700 mid-island -> mode = CTRL and counter = 0 at the next cycle, no island until the next line's cx 644.
REQ-039 SHALL cover: FRAME_WIDTH = 660, SCREEN_WIDTH = 640 -> N_FIT = 0, no islands ever.
REQ-040 SHALL cover: cx forced from 700 to 0 mid-island -> overrun = 1 and mode = CTRL on the next cycle, overrun sticky until reset.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: period types and the fixed lengths of data-island
// sections, plus the elaboration-time packet-fit calculation.
package hdmi_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL           = 3'd0,
    MODE_DI_PREAMBLE    = 3'd1,
    MODE_DI_GUARD_LEAD  = 3'd2,
    MODE_DI_DATA        = 3'd3,
    MODE_DI_GUARD_TRAIL = 3'd4
  } mode_t;

  localparam int PREAMBLE_LEN     = 8;
  localparam int GUARD_LEN        = 2;
  localparam int PACKET_LEN       = 32;
  localparam int MAX_PACKETS_SPEC = 18;

  // Whole packets that fit in horizontal blanking after the 30 pixels of
  // island overhead (lead-in gap, preamble, guards), capped at max_packets.
  function automatic int packets_that_fit(input int frame_width, input int screen_width,
                                          input int max_packets);
    int room;
    room = frame_width - screen_width - 30;
    if (room < 0) return 0;
    return (room / PACKET_LEN < max_packets) ? room / PACKET_LEN : max_packets;
  endfunction

endpackage

// File: rtl/data_island_scheduler.sv
// Schedules one HDMI data island per line inside horizontal blanking and
// paces the packet picker through packet_enable / packet_pixel_counter.
module data_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH  = 800,
  parameter int SCREEN_WIDTH = 640,
  parameter int BIT_WIDTH    = 10,
  parameter int MAX_PACKETS  = MAX_PACKETS_SPEC
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic                 data_island_enable,
  input  logic                 packet_pending,
  output logic [2:0]           mode,
  output logic                 packet_enable,
  output logic [4:0]           packet_pixel_counter,
  output logic                 overrun
);

  localparam int                   N_FIT         = packets_that_fit(FRAME_WIDTH, SCREEN_WIDTH, MAX_PACKETS);
  localparam logic [4:0]           N_FIT_W       = 5'(N_FIT);
  localparam logic [BIT_WIDTH-1:0] ISLAND_START  = BIT_WIDTH'(SCREEN_WIDTH + 4);
  localparam logic [BIT_WIDTH-1:0] SCREEN_END    = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [2:0]           PREAMBLE_LAST = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0]           GUARD_LAST    = 3'(GUARD_LEN - 1);
  localparam logic [4:0]           PACKET_LAST   = 5'(PACKET_LEN - 1);
  localparam logic [4:0]           PACKET_DECIDE = 5'(PACKET_LEN - 2);

  mode_t      mode_reg, mode_next;
  logic [2:0] phase_reg, phase_next;
  logic [4:0] pixel_reg, pixel_next;
  logic [4:0] sent_reg, sent_next;
  logic       enable_reg, enable_next;
  logic       overrun_reg, overrun_next;
  logic       more_reg, more_next;
  logic       start_island;
  logic       collide;

  assign start_island = (mode_reg == MODE_CTRL) && (cx == ISLAND_START) &&
                        data_island_enable && packet_pending && (N_FIT > 0);
  assign collide      = (mode_reg != MODE_CTRL) && (cx < SCREEN_END);

  always_comb begin
    mode_next    = mode_reg;
    phase_next   = phase_reg;
    pixel_next   = 5'd0;
    sent_next    = sent_reg;
    enable_next  = 1'b0;
    overrun_next = overrun_reg;
    more_next    = more_reg;

    case (mode_reg)
      MODE_CTRL: begin
        if (start_island) begin
          mode_next  = MODE_DI_PREAMBLE;
          phase_next = 3'd0;
          sent_next  = 5'd0;
        end
      end
      MODE_DI_PREAMBLE: begin
        if (phase_reg == PREAMBLE_LAST) begin
          mode_next  = MODE_DI_GUARD_LEAD;
          phase_next = 3'd0;
        end else begin
          phase_next = phase_reg + 3'd1;
        end
      end
      MODE_DI_GUARD_LEAD: begin
        if (phase_reg == GUARD_LAST) begin
          mode_next  = MODE_DI_DATA;
          phase_next = 3'd0;
          sent_next  = sent_reg + 5'd1;
        end else begin
          phase_next  = phase_reg + 3'd1;
          enable_next = (phase_reg == GUARD_LAST - 3'd1);
        end
      end
      MODE_DI_DATA: begin
        pixel_next = pixel_reg + 5'd1;
        // Decide one pixel early so the registered enable lands on pixel 31.
        if (pixel_reg == PACKET_DECIDE) begin
          more_next   = packet_pending && (sent_reg < N_FIT_W);
          enable_next = packet_pending && (sent_reg < N_FIT_W);
        end
        if (pixel_reg == PACKET_LAST) begin
          if (more_reg) begin
            sent_next = sent_reg + 5'd1;
          end else begin
            mode_next  = MODE_DI_GUARD_TRAIL;
            pixel_next = 5'd0;
            phase_next = 3'd0;
          end
        end
      end
      MODE_DI_GUARD_TRAIL: begin
        if (phase_reg == GUARD_LAST) begin
          mode_next  = MODE_CTRL;
          phase_next = 3'd0;
        end else begin
          phase_next = phase_reg + 3'd1;
        end
      end
      default: begin
        mode_next  = MODE_CTRL;
        phase_next = 3'd0;
      end
    endcase

    // Island ran into active video: drop straight back to control.
    if (collide) begin
      mode_next    = MODE_CTRL;
      phase_next   = 3'd0;
      pixel_next   = 5'd0;
      enable_next  = 1'b0;
      more_next    = 1'b0;
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_reg    <= MODE_CTRL;
      phase_reg   <= 3'd0;
      pixel_reg   <= 5'd0;
      sent_reg    <= 5'd0;
      enable_reg  <= 1'b0;
      overrun_reg <= 1'b0;
      more_reg    <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      phase_reg   <= phase_next;
      pixel_reg   <= pixel_next;
      sent_reg    <= sent_next;
      enable_reg  <= enable_next;
      overrun_reg <= overrun_next;
      more_reg    <= more_next;
    end
  end

  assign mode                 = mode_reg;
  assign packet_enable        = enable_reg;
  assign packet_pixel_counter = pixel_reg;
  assign overrun              = overrun_reg;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Randomised line-by-line stimulus with an island-timeline reference model
// feeding a per-cycle scoreboard; a second instance has no room for islands.
module tb_data_island_scheduler;
  import hdmi_pkg::*;

  localparam int FW   = 800;
  localparam int SW   = 640;
  localparam int IS   = SW + 4;
  localparam int ROOM = (FW - SW - 30) / 32;
  localparam int NFIT = (ROOM < 18) ? ROOM : 18;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic       reset, data_island_enable, packet_pending;
  logic [9:0] cx;
  logic [2:0] mode;
  logic       packet_enable, overrun;
  logic [4:0] packet_pixel_counter;

  logic       reset2;
  logic [9:0] cx2;
  logic       en2, pend2;
  logic [2:0] mode2;
  logic       packet_enable2, overrun2;
  logic [4:0] packet_pixel_counter2;

  data_island_scheduler dut (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx),
    .data_island_enable(data_island_enable), .packet_pending(packet_pending),
    .mode(mode), .packet_enable(packet_enable),
    .packet_pixel_counter(packet_pixel_counter), .overrun(overrun)
  );

  data_island_scheduler #(.FRAME_WIDTH(660), .SCREEN_WIDTH(640)) dut_narrow (
    .clk_pixel(clk_pixel), .reset(reset2), .cx(cx2),
    .data_island_enable(en2), .packet_pending(pend2),
    .mode(mode2), .packet_enable(packet_enable2),
    .packet_pixel_counter(packet_pixel_counter2), .overrun(overrun2)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic [4:0] ppc;
    logic       pe;
    logic       ovr;
  } obs_t;

  typedef struct {
    int   cyc;
    int   cxv;
    obs_t exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  line_no = 0;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  // Reference model: offset of the current cycle within the island timeline
  // (-1 when idle) and the number of packets committed so far.
  int off   = -1;
  int npk   = 0;
  bit ovr_m = 1'b0;

  function automatic obs_t expect_obs();
    obs_t e;
    int   d;
    e      = '0;
    e.ovr  = ovr_m;
    e.mode = MODE_CTRL;
    if (off >= 0 && off < 8) begin
      e.mode = MODE_DI_PREAMBLE;
    end else if (off >= 8 && off < 10) begin
      e.mode = MODE_DI_GUARD_LEAD;
      e.pe   = (off == 9);
    end else if (off >= 10) begin
      d = off - 10;
      if (d < 32 * npk) begin
        e.mode = MODE_DI_DATA;
        e.ppc  = 5'(d % 32);
        e.pe   = (d % 32 == 31) && (d / 32 < npk - 1);
      end else begin
        e.mode = MODE_DI_GUARD_TRAIL;
      end
    end
    return e;
  endfunction

  task automatic step(input int cxv, input bit en, input bit pend, input bit rst);
    int d;
    @(posedge clk_pixel);
    #1;
    cx                 = 10'(cxv);
    data_island_enable = en;
    packet_pending     = pend;
    reset              = rst;
    if (rst) begin
      off   = -1;
      ovr_m = 1'b0;
    end else if (off >= 0 && cxv < SW) begin
      off   = -1;
      ovr_m = 1'b1;
    end else if (off < 0) begin
      if (cxv == IS && en && pend && NFIT > 0) begin
        off = 0;
        npk = 1;
      end
    end else begin
      if (off >= 10) begin
        d = off - 10;
        if (d % 32 == 30 && d / 32 == npk - 1 && pend && npk < NFIT) npk++;
      end
      off++;
      if (off >= 12 + 32 * npk) off = -1;
    end
    sb_q.push_back('{cyc + 1, cxv, expect_obs()});
  endtask

  // pend_mode: 0 = held high, 1 = high only at the island-start column,
  // 2 = random, changing only on 8-pixel boundaries.
  task automatic run_line(input bit en, input int pend_mode, input int rst_at, input int jump_at);
    int c;
    bit jumped;
    bit pend_r;
    bit pend;
    c      = 0;
    jumped = 1'b0;
    pend_r = 1'b1;
    line_no++;
    $display("line %0d en=%0b pend_mode=%0d rst_at=%0d jump_at=%0d",
             line_no, en, pend_mode, rst_at, jump_at);
    while (c < FW) begin
      if (c % 8 == 0) pend_r = ($urandom_range(0, 3) != 0);
      case (pend_mode)
        0:       pend = 1'b1;
        1:       pend = (c == IS);
        default: pend = pend_r;
      endcase
      step(c, en, pend, c == rst_at);
      if (c == jump_at && !jumped) begin
        c      = 0;
        jumped = 1'b1;
      end else begin
        c++;
      end
    end
  endtask

  // Monitor: pops the expectation tagged for this cycle and compares.
  initial begin
    sb_t  s;
    obs_t got;
    forever begin
      @(negedge clk_pixel);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        s = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL sb_missed cyc=%0d cx=%0d expectation never compared", s.cyc, s.cxv);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        s   = sb_q.pop_front();
        got = {mode, packet_pixel_counter, packet_enable, overrun};
        checks++;
        if (got !== s.exp) begin
          errors++;
          $display("FAIL sb cyc=%0d cx=%0d got mode=%0d ppc=%0d pe=%0b ovr=%0b want mode=%0d ppc=%0d pe=%0b ovr=%0b",
                   cyc, s.cxv, got.mode, got.ppc, got.pe, got.ovr,
                   s.exp.mode, s.exp.ppc, s.exp.pe, s.exp.ovr);
        end
      end
      if (cyc >= 2) begin
        checks++;
        if (mode2 !== 3'(MODE_CTRL) || packet_enable2 !== 1'b0 || overrun2 !== 1'b0 ||
            packet_pixel_counter2 !== 5'd0) begin
          errors++;
          $display("FAIL narrow_idle cyc=%0d cx2=%0d got mode=%0d pe=%0b ovr=%0b ppc=%0d want all idle",
                   cyc, cx2, mode2, packet_enable2, overrun2, packet_pixel_counter2);
        end
      end
    end
  end

  // Narrow-frame instance: free-running 660-pixel lines, islands always wanted.
  initial begin
    cx2    = 10'd0;
    en2    = 1'b1;
    pend2  = 1'b1;
    reset2 = 1'b1;
    repeat (2) begin
      @(posedge clk_pixel);
      #1;
    end
    reset2 = 1'b0;
    forever begin
      @(posedge clk_pixel);
      #1;
      cx2 = (cx2 == 10'd659) ? 10'd0 : cx2 + 10'd1;
    end
  end

  initial begin
    bit en_r;
    int rst_r;
    int jump_r;
    reset              = 1'b1;
    cx                 = 10'd0;
    data_island_enable = 1'b0;
    packet_pending     = 1'b0;

    repeat (3) step(0, 1'b0, 1'b0, 1'b1);

    run_line(1'b1, 0, -1, -1);          // full island of NFIT packets
    run_line(1'b1, 1, -1, -1);          // single packet
    repeat (3) run_line(1'b0, 0, -1, -1); // DVI mode, no islands
    run_line(1'b1, 0, 700, -1);         // reset mid-island
    run_line(1'b1, 0, -1, -1);
    run_line(1'b1, 0, -1, 700);         // cx wraps mid-island -> overrun
    run_line(1'b1, 0, -1, -1);          // overrun stays set
    run_line(1'b1, 0, 10, -1);          // reset clears overrun

    repeat (16) begin
      en_r   = ($urandom_range(0, 5) != 0);
      rst_r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 799)) : -1;
      jump_r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(645, 799)) : -1;
      run_line(en_r, 2, rst_r, jump_r);
    end

    repeat (3) @(posedge clk_pixel);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
